// File: rtl/reg_file_sb_if.sv
// Register-file / scoreboard port bundle: read ports, writeback port, issue port and status.
interface reg_file_sb_if #(
  parameter int unsigned WIDTH = 32
);
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic [WIDTH-1:0] rs1_data;
  logic [WIDTH-1:0] rs2_data;
  logic             wr_en;
  logic [4:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             issue_en;
  logic [4:0]       issue_rd;
  logic             rs1_busy;
  logic             rs2_busy;
  logic             stall;
  logic [5:0]       pending_cnt;

  modport master (
    output rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, stall, pending_cnt
  );

  modport slave (
    input  rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, stall, pending_cnt
  );
endinterface

// File: rtl/reg_file_sb.sv
// 32 x WIDTH register file with a busy-bit scoreboard guarding RAW/WAW hazards at issue.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data and busy clears to the read/issue side.
module reg_file_sb #(
  parameter int unsigned WIDTH = 32
) (
  input logic        clk,
  input logic        reset,
  reg_file_sb_if.slave bus
);

  logic [WIDTH-1:0] regs [32];
  logic [31:0]      busy;
  logic [5:0]       cnt;

  logic wr_ok;
  logic fwd1, fwd2, fwd_rd;
  logic rd_busy;
  logic set, clr;

  assign wr_ok = bus.wr_en && (bus.wr_addr != 5'd0);

`ifdef REGFILE_BYPASS_EN
  assign fwd1   = wr_ok && (bus.wr_addr == bus.rs1_addr);
  assign fwd2   = wr_ok && (bus.wr_addr == bus.rs2_addr);
  assign fwd_rd = wr_ok && (bus.wr_addr == bus.issue_rd);
`else
  assign fwd1   = 1'b0;
  assign fwd2   = 1'b0;
  assign fwd_rd = 1'b0;
`endif

  always_comb begin
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    if (bus.rs1_addr != 5'd0) bus.rs1_data = fwd1 ? bus.wr_data : regs[bus.rs1_addr];
    if (bus.rs2_addr != 5'd0) bus.rs2_data = fwd2 ? bus.wr_data : regs[bus.rs2_addr];
  end

  always_comb begin
    bus.rs1_busy = (bus.rs1_addr != 5'd0) && busy[bus.rs1_addr] && !fwd1;
    bus.rs2_busy = (bus.rs2_addr != 5'd0) && busy[bus.rs2_addr] && !fwd2;
    rd_busy      = (bus.issue_rd != 5'd0) && busy[bus.issue_rd] && !fwd_rd;
    bus.stall    = bus.issue_en && (bus.rs1_busy || bus.rs2_busy || rd_busy);
  end

  // A set and clear of the same register can only coincide through the bypass path;
  // the set is applied last so the bit stays 1 and the count nets to zero.
  assign set = bus.issue_en && !bus.stall && (bus.issue_rd != 5'd0);
  assign clr = wr_ok && busy[bus.wr_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
      busy <= '0;
      cnt  <= '0;
    end else begin
      if (wr_ok) regs[bus.wr_addr] <= bus.wr_data;
      if (clr)   busy[bus.wr_addr] <= 1'b0;
      if (set)   busy[bus.issue_rd] <= 1'b1;
      case ({set, clr})
        2'b10:   cnt <= cnt + 6'd1;
        2'b01:   cnt <= cnt - 6'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign bus.pending_cnt = cnt;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb; expectations follow REGFILE_BYPASS_EN when defined.
module tb_reg_file_sb;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  reg_file_sb_if #(.WIDTH(32)) bus ();
  reg_file_sb #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rs1_addr = '0; bus.rs2_addr = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.issue_en = 1'b0; bus.issue_rd = '0;
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    bus.issue_en = 1'b1; bus.issue_rd = 5'd5; bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd6;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
    total++; if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b%b exp=00", bus.rs1_busy, bus.rs2_busy); end
    total++; if (bus.pending_cnt !== 6'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", bus.pending_cnt); end
    total++; if (bus.rs1_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", bus.rs1_data); end
    idle();
  endtask

  task automatic test_write_read();
    bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hDEADBEEF; bus.rs1_addr = 5'd5;
    #1;
    total++; if (bus.rs1_data !== (BYP ? 32'hDEADBEEF : 32'h0)) begin bad++; $display("FAIL wr_same_cycle got=%h", bus.rs1_data); end
    tick();
    bus.wr_en = 1'b0; bus.rs2_addr = 5'd5;
    #1;
    total++; if (bus.rs1_data !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_x5 got=%h exp=deadbeef", bus.rs1_data); end
    total++; if (bus.rs2_data !== 32'hDEADBEEF) begin bad++; $display("FAIL rd2_x5 got=%h exp=deadbeef", bus.rs2_data); end
    bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'h1234; bus.rs1_addr = 5'd0;
    #1;
    total++; if (bus.rs1_data !== 32'h0) begin bad++; $display("FAIL x0_fwd got=%h exp=0", bus.rs1_data); end
    tick();
    bus.wr_en = 1'b0;
    #1;
    total++; if (bus.rs1_data !== 32'h0) begin bad++; $display("FAIL x0_read got=%h exp=0", bus.rs1_data); end
    total++; if (bus.pending_cnt !== 6'd0) begin bad++; $display("FAIL x0_cnt got=%0d exp=0", bus.pending_cnt); end
    idle();
  endtask

  task automatic test_scoreboard();
    bus.issue_en = 1'b1; bus.issue_rd = 5'd7;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL issue7_stall got=%b exp=0", bus.stall); end
    tick();
    idle();
    total++; if (bus.pending_cnt !== 6'd1) begin bad++; $display("FAIL issue7_cnt got=%0d exp=1", bus.pending_cnt); end
    bus.issue_en = 1'b1; bus.issue_rd = 5'd8; bus.rs2_addr = 5'd7;
    #1;
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL raw_stall got=%b exp=1", bus.stall); end
    total++; if (bus.rs2_busy !== 1'b1) begin bad++; $display("FAIL raw_busy got=%b exp=1", bus.rs2_busy); end
    tick();
    total++; if (bus.stall !== 1'b1 || bus.pending_cnt !== 6'd1) begin bad++; $display("FAIL raw_hold got stall=%b cnt=%0d exp 1/1", bus.stall, bus.pending_cnt); end
    idle();
    bus.issue_en = 1'b1; bus.issue_rd = 5'd7;
    #1;
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL waw_stall got=%b exp=1", bus.stall); end
    idle();
    bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h77;
    tick();
    idle();
    total++; if (bus.pending_cnt !== 6'd0) begin bad++; $display("FAIL wb7_cnt got=%0d exp=0", bus.pending_cnt); end
    bus.issue_en = 1'b1; bus.issue_rd = 5'd8; bus.rs2_addr = 5'd7;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL wb7_stall got=%b exp=0", bus.stall); end
    total++; if (bus.rs2_data !== 32'h77) begin bad++; $display("FAIL wb7_data got=%h exp=77", bus.rs2_data); end
    idle();
  endtask

  task automatic test_bypass();
    bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h11111111;
    tick();
    idle();
    total++; if (bus.pending_cnt !== 6'd0) begin bad++; $display("FAIL plain_wr_cnt got=%0d exp=0", bus.pending_cnt); end
    bus.issue_en = 1'b1; bus.issue_rd = 5'd9;
    tick();
    idle();
    total++; if (bus.pending_cnt !== 6'd1) begin bad++; $display("FAIL issue9_cnt got=%0d exp=1", bus.pending_cnt); end
    bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'hA5A5A5A5;
    bus.rs1_addr = 5'd9; bus.issue_en = 1'b1; bus.issue_rd = 5'd10;
    #1;
    total++; if (bus.rs1_data !== (BYP ? 32'hA5A5A5A5 : 32'h11111111)) begin bad++; $display("FAIL byp_data got=%h", bus.rs1_data); end
    total++; if (bus.stall !== !BYP) begin bad++; $display("FAIL byp_stall got=%b exp=%b", bus.stall, !BYP); end
    total++; if (bus.rs1_busy !== !BYP) begin bad++; $display("FAIL byp_busy got=%b exp=%b", bus.rs1_busy, !BYP); end
    tick();
    idle();
    total++; if (bus.pending_cnt !== (BYP ? 6'd1 : 6'd0)) begin bad++; $display("FAIL byp_cnt got=%0d exp=%0d", bus.pending_cnt, BYP ? 1 : 0); end
    bus.rs1_addr = 5'd9;
    #1;
    total++; if (bus.rs1_data !== 32'hA5A5A5A5) begin bad++; $display("FAIL byp_after got=%h exp=a5a5a5a5", bus.rs1_data); end
    bus.wr_en = 1'b1; bus.wr_addr = 5'd10; bus.wr_data = 32'h10;
    tick();
    idle();
    total++; if (bus.pending_cnt !== 6'd0) begin bad++; $display("FAIL byp_clean got=%0d exp=0", bus.pending_cnt); end
  endtask

  task automatic test_same_cycle();
    bus.issue_en = 1'b1; bus.issue_rd = 5'd3;
    tick();
    idle();
    total++; if (bus.pending_cnt !== 6'd1) begin bad++; $display("FAIL issue3_cnt got=%0d exp=1", bus.pending_cnt); end
    bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'h33;
    bus.issue_en = 1'b1; bus.issue_rd = 5'd3;
    #1;
    total++; if (bus.stall !== !BYP) begin bad++; $display("FAIL same_stall got=%b exp=%b", bus.stall, !BYP); end
    tick();
    idle();
    bus.rs1_addr = 5'd3;
    #1;
    total++; if (bus.rs1_busy !== BYP) begin bad++; $display("FAIL same_busy got=%b exp=%b", bus.rs1_busy, BYP); end
    total++; if (bus.pending_cnt !== (BYP ? 6'd1 : 6'd0)) begin bad++; $display("FAIL same_cnt got=%0d exp=%0d", bus.pending_cnt, BYP ? 1 : 0); end
    total++; if (bus.rs1_data !== 32'h33) begin bad++; $display("FAIL same_data got=%h exp=33", bus.rs1_data); end
    bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'h33;
    tick();
    idle();
    total++; if (bus.pending_cnt !== 6'd0) begin bad++; $display("FAIL same_clean got=%0d exp=0", bus.pending_cnt); end
  endtask

  task automatic test_fill_and_reset();
    for (int r = 1; r < 32; r++) begin
      bus.issue_en = 1'b1; bus.issue_rd = r[4:0];
      #1;
      total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL fill_stall rd=%0d got=%b exp=0", r, bus.stall); end
      tick();
    end
    idle();
    total++; if (bus.pending_cnt !== 6'd31) begin bad++; $display("FAIL fill_cnt got=%0d exp=31", bus.pending_cnt); end
    bus.issue_en = 1'b1; bus.issue_rd = 5'd0;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL x0_issue_stall got=%b exp=0", bus.stall); end
    tick();
    total++; if (bus.pending_cnt !== 6'd31) begin bad++; $display("FAIL x0_issue_cnt got=%0d exp=31", bus.pending_cnt); end
    // reset must win over a concurrent writeback and issue
    reset = 1'b1;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hFFFFFFFF;
    bus.issue_en = 1'b1; bus.issue_rd = 5'd0;
    tick();
    reset = 1'b0;
    idle();
    bus.issue_en = 1'b1; bus.issue_rd = 5'd31; bus.rs1_addr = 5'd31; bus.rs2_addr = 5'd5;
    #1;
    total++; if (bus.pending_cnt !== 6'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", bus.pending_cnt); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", bus.stall); end
    total++; if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b%b exp=00", bus.rs1_busy, bus.rs2_busy); end
    idle();
    for (int r = 0; r < 32; r++) begin
      bus.rs1_addr = r[4:0];
      #1;
      total++; if (bus.rs1_data !== 32'h0) begin bad++; $display("FAIL rst_reg x%0d got=%h exp=0", r, bus.rs1_data); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_scoreboard();
    test_bypass();
    test_same_cycle();
    test_fill_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
